layered_rgb_mux: RTL and testbench

//  Parametrised, pipelined successor to the fixed-priority VGA object mux. Selects one RGB
//  per pixel from NUM_LAYERS drawing layers (index 0 = highest priority) over a background.

---
 rtl/layered_rgb_mux.sv | 206 ++++++++++++++++++++
 tb/tb_layered_rgb_mux.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/layered_rgb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : layered_rgb_mux
//  Description : Pipelined priority mux selecting one RGB pixel per cycle from
//                NUM_LAYERS drawing layers (index 0 = highest priority) over a
//                background. Adds per-layer enable, colour-key transparency,
//                frame-based blinking, a per-frame occlusion report and a
//                full-screen damage-flash tint. Latency is 2 cycles.
//
//  Ports       : clk            pixel clock
//                reset          synchronous, active-high
//                layerDR        per-layer drawing request
//                layerRGB       layer i pixel at [i*RGB_W +: RGB_W]
//                backgroundRGB  pixel used when no layer wins
//                layerEnable    quasi-static per-layer enable
//                blinkMask      layers hidden during the blink-off phase
//                startOfFrame   1-cycle pulse on the first pixel of a frame
//                flashReq       1-cycle pulse to start/restart a damage flash
//                RGBOut         final pixel
//                winnerIdx      winning layer, aligned with RGBOut
//                winnerValid    1 = a layer won, 0 = background
//                overlapFrame   occlusion report of the previous frame
//
//  Revision    : 1.0  initial release
// ============================================================================
module layered_rgb_mux #(
    parameter int               NUM_LAYERS   = 16,
    parameter int               RGB_W        = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT  = 8'hFF,
    parameter int               BLINK_LOG2   = 5,
    parameter int               FLASH_FRAMES = 8,
    parameter logic [RGB_W-1:0] FLASH_COLOR  = 8'hE0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LAYERS-1:0]         layerDR,
    input  logic [NUM_LAYERS*RGB_W-1:0]   layerRGB,
    input  logic [RGB_W-1:0]              backgroundRGB,
    input  logic [NUM_LAYERS-1:0]         layerEnable,
    input  logic [NUM_LAYERS-1:0]         blinkMask,
    input  logic                          startOfFrame,
    input  logic                          flashReq,
    output logic [RGB_W-1:0]              RGBOut,
    output logic [$clog2(NUM_LAYERS)-1:0] winnerIdx,
    output logic                          winnerValid,
    output logic [NUM_LAYERS-1:0]         overlapFrame
);

    localparam int         IDX_W        = $clog2(NUM_LAYERS);
    localparam logic [7:0] C_FLASH_LOAD = 8'(FLASH_FRAMES);
    localparam logic [7:0] C_FLASH_LAST = 8'd1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLASH = 1'b1
    } flash_state_t;

    // Frame counter / blink phase
    logic [BLINK_LOG2-1:0] r_frame_cnt_q, w_frame_cnt_d;
    logic                  w_blink_off;

    // Flash FSM
    flash_state_t          r_flash_state_q, w_flash_state_d;
    logic [7:0]            r_flash_cnt_q, w_flash_cnt_d;

    // Occlusion tracking
    logic [NUM_LAYERS-1:0] r_ov_acc_q, w_ov_acc_d;
    logic [NUM_LAYERS-1:0] r_overlap_q, w_overlap_d;

    // Pipeline stage 1 (selection) and stage 2 (tint)
    logic [RGB_W-1:0]      r_sel_rgb_q, w_sel_rgb_d;
    logic [IDX_W-1:0]      r_sel_idx_q, w_sel_idx_d;
    logic                  r_sel_valid_q, w_sel_valid_d;
    logic [RGB_W-1:0]      r_rgb_out_q, w_rgb_out_d;
    logic [IDX_W-1:0]      r_win_idx_q, w_win_idx_d;
    logic                  r_win_valid_q, w_win_valid_d;

    logic [NUM_LAYERS-1:0] w_eff;
    logic [NUM_LAYERS-1:0] w_ov_contrib;

    // The blink phase is the counter MSB, giving a 50% duty over 2^BLINK_LOG2 frames.
    assign w_blink_off = r_frame_cnt_q[BLINK_LOG2-1];

    // A layer is effectively drawing only if requested, enabled, not blinked
    // out and not showing the colour key.
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_eff
            assign w_eff[gi] = layerDR[gi] & layerEnable[gi]
                             & ~(blinkMask[gi] & w_blink_off)
                             & (layerRGB[gi*RGB_W +: RGB_W] != TRANSPARENT);
        end
    endgenerate

    // A layer is occluded when any higher-priority (lower index) layer also draws.
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_ov
            if (gi == 0) begin : g_top
                assign w_ov_contrib[gi] = 1'b0;
            end else begin : g_lower
                assign w_ov_contrib[gi] = w_eff[gi] & (|w_eff[gi-1:0]);
            end
        end
    endgenerate

    // Stage 1: priority select. Scanning downward lets the lowest index win.
    always_comb begin
        w_sel_rgb_d   = backgroundRGB;
        w_sel_idx_d   = '0;
        w_sel_valid_d = |w_eff;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_eff[i]) begin
                w_sel_rgb_d = layerRGB[i*RGB_W +: RGB_W];
                w_sel_idx_d = IDX_W'(i);
            end
        end
    end

    // Stage 2: tint with the flash colour while the FSM is flashing.
    always_comb begin
        w_rgb_out_d   = r_sel_rgb_q;
        w_win_idx_d   = r_sel_idx_q;
        w_win_valid_d = r_sel_valid_q;
        if (r_flash_state_q == ST_FLASH) begin
            w_rgb_out_d = r_sel_rgb_q | FLASH_COLOR;
        end
    end

    // Frame counter and occlusion accumulator. The startOfFrame pixel already
    // belongs to the new frame, so its contribution seeds the fresh accumulator.
    always_comb begin
        w_frame_cnt_d = r_frame_cnt_q;
        w_ov_acc_d    = r_ov_acc_q | w_ov_contrib;
        w_overlap_d   = r_overlap_q;
        if (startOfFrame) begin
            w_frame_cnt_d = r_frame_cnt_q + 1'b1;
            w_overlap_d   = r_ov_acc_q;
            w_ov_acc_d    = w_ov_contrib;
        end
    end

    // Flash FSM: a request always (re)loads the full duration, taking
    // precedence over a coincident frame-boundary decrement.
    always_comb begin
        w_flash_state_d = r_flash_state_q;
        w_flash_cnt_d   = r_flash_cnt_q;
        case (r_flash_state_q)
            ST_IDLE: begin
                if (flashReq) begin
                    w_flash_state_d = ST_FLASH;
                    w_flash_cnt_d   = C_FLASH_LOAD;
                end
            end
            ST_FLASH: begin
                if (flashReq) begin
                    w_flash_cnt_d = C_FLASH_LOAD;
                end else if (startOfFrame) begin
                    if (r_flash_cnt_q == C_FLASH_LAST) begin
                        w_flash_state_d = ST_IDLE;
                        w_flash_cnt_d   = '0;
                    end else begin
                        w_flash_cnt_d = r_flash_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                w_flash_state_d = ST_IDLE;
                w_flash_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt_q   <= '0;
            r_flash_state_q <= ST_IDLE;
            r_flash_cnt_q   <= '0;
            r_ov_acc_q      <= '0;
            r_overlap_q     <= '0;
            r_sel_rgb_q     <= '0;
            r_sel_idx_q     <= '0;
            r_sel_valid_q   <= 1'b0;
            r_rgb_out_q     <= '0;
            r_win_idx_q     <= '0;
            r_win_valid_q   <= 1'b0;
        end else begin
            r_frame_cnt_q   <= w_frame_cnt_d;
            r_flash_state_q <= w_flash_state_d;
            r_flash_cnt_q   <= w_flash_cnt_d;
            r_ov_acc_q      <= w_ov_acc_d;
            r_overlap_q     <= w_overlap_d;
            r_sel_rgb_q     <= w_sel_rgb_d;
            r_sel_idx_q     <= w_sel_idx_d;
            r_sel_valid_q   <= w_sel_valid_d;
            r_rgb_out_q     <= w_rgb_out_d;
            r_win_idx_q     <= w_win_idx_d;
            r_win_valid_q   <= w_win_valid_d;
        end
    end

    assign RGBOut       = r_rgb_out_q;
    assign winnerIdx    = r_win_idx_q;
    assign winnerValid  = r_win_valid_q;
    assign overlapFrame = r_overlap_q;

endmodule
`default_nettype wire

// File: tb/tb_layered_rgb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layered_rgb_mux
//  Description : Self-checking bench for layered_rgb_mux. A few directed
//                pixels followed by randomized traffic, compared every cycle
//                against a frame/flash-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_layered_rgb_mux;

    localparam int NL = 16;
    localparam int W  = 8;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NL-1:0]   layerDR;
    logic [NL*W-1:0] layerRGB;
    logic [W-1:0]    backgroundRGB;
    logic [NL-1:0]   layerEnable;
    logic [NL-1:0]   blinkMask;
    logic            startOfFrame;
    logic            flashReq;
    logic [W-1:0]    RGBOut;
    logic [IW-1:0]   winnerIdx;
    logic            winnerValid;
    logic [NL-1:0]   overlapFrame;

    always #5 clk = ~clk;

    layered_rgb_mux dut (
        .clk           (clk),
        .reset         (reset),
        .layerDR       (layerDR),
        .layerRGB      (layerRGB),
        .backgroundRGB (backgroundRGB),
        .layerEnable   (layerEnable),
        .blinkMask     (blinkMask),
        .startOfFrame  (startOfFrame),
        .flashReq      (flashReq),
        .RGBOut        (RGBOut),
        .winnerIdx     (winnerIdx),
        .winnerValid   (winnerValid),
        .overlapFrame  (overlapFrame)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stimulus for the next cycle
    logic          s_reset;
    logic [NL-1:0] s_dr, s_en, s_bm;
    logic [W-1:0]  s_rgb [NL];
    logic [W-1:0]  s_bg;
    logic          s_sof, s_freq;

    // Reference model state
    int            m_frame;     // frames since reset, modulo 32
    int            m_flash;     // flash frames remaining, 0 = not flashing
    logic [NL-1:0] m_acc, m_ovf;
    logic [W-1:0]  m_sel_rgb, m_out_rgb;
    int            m_sel_idx, m_out_idx;
    logic          m_sel_v, m_out_v;

    task automatic model_clear();
        m_frame   = 0;
        m_flash   = 0;
        m_acc     = '0;
        m_ovf     = '0;
        m_sel_rgb = '0;
        m_out_rgb = '0;
        m_sel_idx = 0;
        m_out_idx = 0;
        m_sel_v   = 1'b0;
        m_out_v   = 1'b0;
    endtask

    // Advance the model across one rising edge using the stimulus just driven.
    task automatic model_step();
        logic [NL-1:0] e;
        logic [NL-1:0] contrib;
        int            win;
        bit            blink_off;
        if (s_reset) begin
            model_clear();
            return;
        end
        blink_off = (m_frame >= 16);
        for (int i = 0; i < NL; i++)
            e[i] = s_dr[i] && s_en[i] && !(s_bm[i] && blink_off) && (s_rgb[i] != 8'hFF);
        win = -1;
        for (int i = 0; i < NL; i++)
            if (e[i] && win < 0) win = i;
        // Every drawing layer except the top-priority one is occluded.
        contrib = e & (e - 16'd1);

        m_out_rgb = (m_flash > 0) ? (m_sel_rgb | 8'hE0) : m_sel_rgb;
        m_out_idx = m_sel_idx;
        m_out_v   = m_sel_v;

        m_sel_v   = (win >= 0);
        m_sel_idx = (win >= 0) ? win : 0;
        m_sel_rgb = (win >= 0) ? s_rgb[win] : s_bg;

        if (s_sof) begin
            m_ovf = m_acc;
            m_acc = contrib;
        end else begin
            m_acc = m_acc | contrib;
        end
        if (s_sof) m_frame = (m_frame + 1) % 32;
        if (s_freq) m_flash = 8;
        else if (s_sof && m_flash > 0) m_flash = m_flash - 1;
    endtask

    // Check outputs produced by the previous edge, then drive the next pixel.
    task automatic cycle();
        @(negedge clk);
        chk("RGBOut", 32'(RGBOut), 32'(m_out_rgb));
        chk("winnerIdx", 32'(winnerIdx), 32'(m_out_idx));
        chk("winnerValid", 32'(winnerValid), 32'(m_out_v));
        chk("overlapFrame", 32'(overlapFrame), 32'(m_ovf));
        reset         = s_reset;
        layerDR       = s_dr;
        layerEnable   = s_en;
        blinkMask     = s_bm;
        backgroundRGB = s_bg;
        startOfFrame  = s_sof;
        flashReq      = s_freq;
        for (int i = 0; i < NL; i++) layerRGB[i*W +: W] = s_rgb[i];
        model_step();
    endtask

    initial begin
        int frame_left;
        reset = 1'b1; layerDR = '0; layerRGB = '0; backgroundRGB = '0;
        layerEnable = '1; blinkMask = '0; startOfFrame = 1'b0; flashReq = 1'b0;
        s_reset = 1'b1; s_dr = '0; s_en = '1; s_bm = '0; s_bg = '0;
        s_sof = 1'b0; s_freq = 1'b0;
        for (int i = 0; i < NL; i++) s_rgb[i] = '0;
        model_clear();
        repeat (2) @(posedge clk);

        // Reset state is checked by the first call.
        cycle();

        // Layers 1 and 2 both draw: layer 1 wins.
        s_reset = 1'b0; s_dr = 16'h0006; s_rgb[1] = 8'h1C; s_rgb[2] = 8'h03;
        repeat (3) cycle();
        chk("t1_rgb", 32'(RGBOut), 32'h1C);
        chk("t1_idx", 32'(winnerIdx), 32'd1);
        chk("t1_valid", 32'(winnerValid), 32'd1);

        // No layer: background. A colour-keyed layer 0 still shows background.
        s_dr = '0; s_bg = 8'h49;
        repeat (3) cycle();
        chk("t2_bg", 32'(RGBOut), 32'h49);
        s_dr = 16'h0001; s_rgb[0] = 8'hFF;
        repeat (3) cycle();
        chk("t2_key", 32'(RGBOut), 32'h49);
        chk("t2_valid", 32'(winnerValid), 32'd0);

        // Flash over layer 2 pixel 0x03.
        s_dr = 16'h0004; s_freq = 1'b1;
        cycle();
        s_freq = 1'b0;
        repeat (2) cycle();
        chk("t5_flash", 32'(RGBOut), 32'hE3);

        // Randomized traffic with short frames so blink phases are exercised.
        frame_left = 4;
        for (int n = 0; n < 4000; n++) begin
            s_reset = ($urandom_range(0, 699) == 0);
            frame_left--;
            s_sof = (frame_left == 0);
            if (s_sof) frame_left = $urandom_range(3, 8);
            s_freq = ($urandom_range(0, 49) == 0);
            s_dr   = NL'($urandom & $urandom);
            if ($urandom_range(0, 99) == 0) s_en = NL'($urandom | $urandom | $urandom);
            if ($urandom_range(0, 99) == 0) s_bm = NL'($urandom);
            s_bg = W'($urandom);
            for (int i = 0; i < NL; i++)
                s_rgb[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
            cycle();
        end

        // Reset mid-traffic: outputs must read zero for two cycles afterwards.
        s_dr = 16'h0001; s_rgb[0] = 8'h5A; s_en = '1; s_reset = 1'b1; s_sof = 1'b0;
        cycle();
        s_reset = 1'b0;
        cycle();
        cycle();
        chk("rst_rgb0", 32'(RGBOut), 32'h00);
        chk("rst_ovf", 32'(overlapFrame), 32'h0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
